// File: rtl/scaler_pkg.sv
// Shared constants for the scaler readout: header marker, FSM states, frame length.
// Frame length grows by one word when SCALER_READOUT_TIMESTAMP_EN is defined.
package scaler_pkg;

  localparam logic [7:0] HDR_MARK = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_HDR,
    ST_TS,
    ST_CHAN
  } state_t;

  function automatic int unsigned frame_len(input int unsigned nch);
`ifdef SCALER_READOUT_TIMESTAMP_EN
    return nch + 2;
`else
    return nch + 1;
`endif
  endfunction

endpackage

// File: rtl/scaler_readout_fifo.sv
// First-word-fall-through FIFO carrying {last, data}; reports free space including
// the word popped in the current cycle so a same-cycle reservation can count it.
module scaler_readout_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [AW:0]      free
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign rdata  = valid ? mem[rptr] : '0;
  assign free   = (AW+1)'(DEPTH) - count + (AW+1)'(do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/scaler_readout.sv
// Gate timer plus frame packer for a bank of scaler channels, streaming via a FWFT FIFO.
// Optional SCALER_READOUT_TIMESTAMP_EN adds a cycle-count word after each header.
module scaler_readout
  import scaler_pkg::*;
#(
  parameter int NCH        = 8,
  parameter int DATA_W     = 32,
  parameter int PERIOD_W   = 32,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PERIOD_W-1:0]   period,
  output logic                  endcount,
  input  logic [NCH*DATA_W-1:0] cnt_in,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [15:0]           frame_seq,
  output logic [15:0]           drop_cnt,
  output logic                  overflow
);

  localparam int L  = frame_len(NCH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [PERIOD_W-1:0] P_MIN = PERIOD_W'(L + 2);
  localparam logic [AW:0]         L_W   = (AW+1)'(L);

  if (DATA_W != 32) begin : g_bad_width
    $error("scaler_readout: DATA_W must be 32");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < NCH + 2) begin : g_bad_depth
    $error("scaler_readout: FIFO_DEPTH must be a power of two and >= NCH+2");
  end

  // Gate timer: period is sampled when the timer sits at 0, clamped so a frame
  // always finishes before the next window closes.
  logic [PERIOD_W-1:0] timer, p_lat;

  assign endcount = enable && (timer != '0) && (timer == p_lat - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
      p_lat <= '0;
    end else if (!enable) begin
      timer <= '0;
    end else if (timer == '0) begin
      p_lat <= (period < P_MIN) ? P_MIN : period;
      timer <= PERIOD_W'(1);
    end else if (endcount) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

`ifdef SCALER_READOUT_TIMESTAMP_EN
  logic [31:0] cyc, ts_lat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc    <= '0;
      ts_lat <= '0;
    end else begin
      cyc <= cyc + 1'b1;
      if (endcount) ts_lat <= cyc;
    end
  end
`endif

  state_t                       state, next;
  logic [NCH-1:0][DATA_W-1:0]   snap;
  logic [CW-1:0]                idx;
  logic                         last_chan, fits, push;
  logic [DATA_W:0]              wdata, rdata;
  logic [AW:0]                  free;

  assign last_chan = (idx == CW'(NCH - 1));
  assign fits      = (free >= L_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE:    if (endcount) next = ST_CAPTURE;
      ST_CAPTURE: next = fits ? ST_HDR : ST_IDLE;
`ifdef SCALER_READOUT_TIMESTAMP_EN
      ST_HDR:     next = ST_TS;
`else
      ST_HDR:     next = ST_CHAN;
`endif
      ST_TS:      next = ST_CHAN;
      ST_CHAN:    if (last_chan) next = ST_IDLE;
      default:    next = ST_IDLE;
    endcase
  end

  always_comb begin
    push  = 1'b0;
    wdata = '0;
    case (state)
      ST_HDR: begin
        push  = 1'b1;
        wdata = {1'b0, HDR_MARK, 8'(NCH), frame_seq};
      end
`ifdef SCALER_READOUT_TIMESTAMP_EN
      ST_TS: begin
        push  = 1'b1;
        wdata = {1'b0, ts_lat};
      end
`endif
      ST_CHAN: begin
        push  = 1'b1;
        wdata = {last_chan, snap[idx]};
      end
      default: ;
    endcase
  end

  // Sequence advances on every capture, including frames that get dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap      <= '0;
      idx       <= '0;
      frame_seq <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (state == ST_CAPTURE) begin
        snap      <= cnt_in;
        frame_seq <= frame_seq + 1'b1;
        if (!fits) begin
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
          overflow <= 1'b1;
        end
      end
      if (state == ST_CHAN) idx <= last_chan ? '0 : idx + 1'b1;
    end
  end

  scaler_readout_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (m_ready),
    .rdata (rdata),
    .valid (m_valid),
    .free  (free)
  );

  assign m_data = rdata[DATA_W-1:0];
  assign m_last = rdata[DATA_W];

endmodule

// File: tb/tb_scaler_readout.sv
// Directed bench for scaler_readout: a frame-level model checked every cycle,
// plus literal expectations for window spacing, stream contents and drops.
module tb_scaler_readout;
  import scaler_pkg::*;

  localparam int NCH   = 4;
  localparam int PW    = 32;
  localparam int DEPTH = 16;
  localparam int L     = frame_len(NCH);
  localparam int PMIN  = L + 2;
  localparam int O     = L - NCH - 1;   // extra timestamp word after the header
`ifdef SCALER_READOUT_TIMESTAMP_EN
  localparam int EXP_SPACING = 8, EXP_DROPS = 2, EXP_WORDS = 12, EXP_LASTS = 2;
`else
  localparam int EXP_SPACING = 7, EXP_DROPS = 1, EXP_WORDS = 15, EXP_LASTS = 3;
`endif

  logic              clk = 0, rst = 1, enable = 0, m_ready = 1;
  logic [PW-1:0]     period = 10;
  logic [NCH*32-1:0] cnt_in;
  logic              endcount, m_valid, m_last, overflow;
  logic [31:0]       m_data;
  logic [15:0]       frame_seq, drop_cnt;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  scaler_readout #(.NCH(NCH), .DATA_W(32), .PERIOD_W(PW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .endcount(endcount),
    .cnt_in(cnt_in), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .frame_seq(frame_seq), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NCH*32-1:0] pack(input logic [31:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  // Model: absolute-cycle window schedule plus a queue of words the FIFO should hold.
  typedef struct { int t; logic [32:0] w; } push_t;
  int          c = 0, win_start = 0, cur_p = PMIN, cap_at = -1, ts_val = 0, fr;
  logic [32:0] mq[$];
  push_t       pend[$];
  push_t       p;
  logic [15:0] seq_m = 0, drop_m = 0;
  logic        ovf_m = 0, exp_ec, pop;
  int          ec_q[$];
  logic [32:0] got_q[$];

  always @(negedge clk) begin
    if (rst) begin
      mq.delete(); pend.delete();
      seq_m = 0; drop_m = 0; ovf_m = 0; c = 0; win_start = 0; cap_at = -1;
      chk("rst_data", m_data, 0);
      chk("rst_flags", {endcount, m_valid, m_last, overflow, frame_seq, drop_cnt}, 0);
    end else begin
      if (enable && c == win_start) cur_p = (period < PMIN) ? PMIN : int'(period);
      exp_ec = enable && (c - win_start == cur_p - 1);
      chk("endcount", endcount, exp_ec);
      chk("m_valid", m_valid, mq.size() != 0);
      if (mq.size() != 0) chk("m_word", {m_last, m_data}, mq[0]);
      chk("frame_seq", frame_seq, seq_m);
      chk("drop_cnt", drop_cnt, drop_m);
      chk("overflow", overflow, ovf_m);
      if (endcount) ec_q.push_back(c);
      if (m_valid && m_ready) got_q.push_back({m_last, m_data});

      pop = (mq.size() != 0) && m_ready;
      if (c == cap_at) begin
        seq_m++;
        if (DEPTH - mq.size() + int'(pop) < L) begin
          if (drop_m != 16'hFFFF) drop_m++;
          ovf_m = 1;
        end else begin
          pend.push_back('{t: c + 1, w: {1'b0, 8'hA5, 8'(NCH), seq_m}});
          fr = c + 2;
`ifdef SCALER_READOUT_TIMESTAMP_EN
          pend.push_back('{t: c + 2, w: {1'b0, 32'(ts_val)}});
          fr = c + 3;
`endif
          for (int k = 0; k < NCH; k++)
            pend.push_back('{t: fr + k, w: {k == NCH - 1, cnt_in[k*32 +: 32]}});
        end
      end
      if (pop) void'(mq.pop_front());
      while (pend.size() != 0 && pend[0].t == c) begin
        p = pend.pop_front();
        mq.push_back(p.w);
      end
      if (exp_ec) begin cap_at = c + 1; ts_val = c; end
      if (!enable || exp_ec) win_start = c + 1;
      c++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int re_c, lasts;

  initial begin
    cnt_in = pack(1, 2, 3, 4);
    step(2);
    rst = 0; enable = 1;

    // Basic frames: period 10, constant counts.
    step(30);
    chk("a_len", got_q.size() >= 6 + O, 1);
    chk("a_ec_count", ec_q.size() >= 2, 1);
    if (ec_q.size() >= 2) begin
      chk("a_ec0", ec_q[0], 9);
      chk("a_ec1", ec_q[1], 19);
    end
    if (got_q.size() >= 6 + O) begin
      chk("a_hdr1", got_q[0], {1'b0, 32'hA504_0001});
      chk("a_ch0", got_q[1 + O], 1);
      chk("a_ch1", got_q[2 + O], 2);
      chk("a_ch2", got_q[3 + O], 3);
      chk("a_ch3", got_q[4 + O], {1'b1, 32'd4});
      chk("a_hdr2", got_q[5 + O], {1'b0, 32'hA504_0002});
    end

    // Short period is clamped.
    period = 2; cnt_in = pack(7, 32'h1234_5678, 0, 32'hFFFF_FFFF);
    ec_q.delete();
    step(30);
    chk("b_ec_count", ec_q.size() >= 2, 1);
    if (ec_q.size() >= 2) chk("b_spacing", ec_q[ec_q.size()-1] - ec_q[ec_q.size()-2], EXP_SPACING);

    // Back-pressure fills the FIFO until a frame must be dropped.
    enable = 0;
    step(20);
    period = 10; m_ready = 0; enable = 1;
    step(45);
    chk("c_drops", drop_cnt, EXP_DROPS);
    chk("c_ovf", overflow, 1);
    enable = 0; got_q.delete(); m_ready = 1;
    step(25);
    lasts = 0;
    foreach (got_q[i]) if (got_q[i][32]) lasts++;
    chk("c_words", got_q.size(), EXP_WORDS);
    chk("c_lasts", lasts, EXP_LASTS);
    chk("c_empty", m_valid, 0);

    // Enable dropped mid-window, then restarted.
    enable = 1;
    step(5);
    enable = 0; ec_q.delete();
    step(8);
    chk("d_quiet", ec_q.size(), 0);
    re_c = c; enable = 1;
    step(15);
    chk("d_ec_seen", ec_q.size() >= 1, 1);
    if (ec_q.size() >= 1) chk("d_reen", ec_q[0] - re_c, 9);

    // Asynchronous reset while channels are being pushed.
    ec_q.delete();
    for (int i = 0; i < 40 && ec_q.size() == 0; i++) step(1);
    chk("e_ec_seen", ec_q.size() != 0, 1);
    step(2);
    rst = 1;
    #1;
    chk("e_rst_data", m_data, 0);
    chk("e_rst_flags", {endcount, m_valid, m_last, overflow, frame_seq, drop_cnt}, 0);
    @(posedge clk); #1;
    rst = 0; got_q.delete(); ec_q.delete();
    step(20);
    chk("e_len", got_q.size() >= 1 && ec_q.size() >= 1, 1);
    if (got_q.size() >= 1) chk("e_hdr", got_q[0], {1'b0, 32'hA504_0001});
    if (ec_q.size() >= 1) chk("e_ec", ec_q[0], 9);

`ifdef SCALER_READOUT_TIMESTAMP_EN
    // Timestamp word reflects the endcount cycle.
    rst = 1; enable = 0;
    step(2);
    rst = 0; got_q.delete();
    step(91);
    enable = 1;
    step(20);
    chk("f_len", got_q.size() >= NCH + 2, 1);
    if (got_q.size() >= NCH + 2) begin
      chk("f_ts", got_q[1], 100);
      chk("f_last", got_q[NCH + 1][32], 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
